// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: shares one data-memory port between zero-latency scalar accesses and LANES-word vector bursts.
// Define ARB_STARVE_GUARD_EN to force a vector beat after MAX_WAIT consecutive preempted burst cycles.
module vec_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LANES = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_req,
    input  logic                s_we,
    input  logic [AW-1:0]       s_addr,
    input  logic [DW-1:0]       s_wdata,
    output logic [DW-1:0]       s_rdata,
    output logic                s_stall,
    input  logic                v_req,
    input  logic                v_we,
    input  logic [AW-1:0]       v_base,
    input  logic [LANES*DW-1:0] v_wdata,
    output logic [LANES*DW-1:0] v_rdata,
    output logic                v_busy,
    output logic                v_done,
    output logic                m_we,
    output logic [AW-1:0]       m_addr,
    output logic [DW-1:0]       m_wdata,
    input  logic [DW-1:0]       m_rdata
);
    localparam int BW = LANES > 1 ? $clog2(LANES) : 1;
    typedef enum logic [1:0] {IDLE, VBURST, VDONE} state_t;
    state_t state, state_n;
    logic [BW-1:0] beat;
    logic [AW-1:0] base;
    logic we_l;
    logic [LANES*DW-1:0] wdata_l;
    logic vslot, sgrant, forced;
`ifdef ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;
    assign forced = wait_cnt == WW'(MAX_WAIT);
`else
    assign forced = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    // reset also gates the scalar path so the port is quiet while reset is held
    always_comb begin
        vslot = state == VBURST && (!s_req || forced);
        sgrant = reset && s_req && !vslot;
        state_n = state == IDLE ? (v_req ? VBURST : IDLE) :
                  state == VDONE ? IDLE :
                  (vslot && beat == BW'(LANES - 1)) ? VDONE : VBURST;
        m_addr = vslot ? base + (AW'(beat) << 2) : sgrant ? s_addr : '0;
        m_we = vslot ? we_l : sgrant & s_we;
        m_wdata = vslot ? wdata_l[beat*DW +: DW] : sgrant ? s_wdata : '0;
        s_rdata = sgrant ? m_rdata : '0;
        s_stall = s_req & vslot;
        v_busy = state != IDLE;
        v_done = state == VDONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat <= '0;
            base <= '0;
            we_l <= 1'b0;
            wdata_l <= '0;
            v_rdata <= '0;
`ifdef ARB_STARVE_GUARD_EN
            wait_cnt <= '0;
`endif
        end else if (state == IDLE) begin
            if (v_req) begin
                base <= v_base;
                we_l <= v_we;
                wdata_l <= v_wdata;
                beat <= '0;
`ifdef ARB_STARVE_GUARD_EN
                wait_cnt <= '0;
`endif
            end
        end else if (vslot) begin
            if (!we_l) v_rdata[beat*DW +: DW] <= m_rdata;
            beat <= beat + 1'b1;
`ifdef ARB_STARVE_GUARD_EN
            wait_cnt <= '0;
        end else if (state == VBURST) begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb_vec_mem_arbiter: randomized scenarios scored cycle-by-cycle against a transaction-level model of the shared port.
module tb_vec_mem_arbiter;
    localparam int AW = 32, DW = 32, LANES = 4, MAX_WAIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0;
    logic s_req = 0, s_we = 0, s_stall, v_req = 0, v_we = 0, v_busy, v_done, m_we;
    logic [31:0] s_addr = 0, s_wdata = 0, s_rdata, v_base = 0, m_addr, m_wdata, m_rdata;
    logic [127:0] v_wdata = 0, v_rdata;
    logic [31:0] mem [256];
    logic [31:0] gold [256];
    logic [127:0] vr_model = '0;
    int checks = 0, errors = 0, scn = 0;

    typedef struct {
        int scn; int cyc;
        logic [31:0] addr, wd, rd;
        logic we, stall, done, busy, chk_rd, chk_vr;
        logic [127:0] vr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    vec_mem_arbiter #(.AW(AW), .DW(DW), .LANES(LANES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_stall(s_stall), .v_req(v_req), .v_we(v_we), .v_base(v_base),
        .v_wdata(v_wdata), .v_rdata(v_rdata), .v_busy(v_busy), .v_done(v_done), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;
    assign m_rdata = mem[m_addr[9:2]];
    always @(posedge clk) if (m_we) mem[m_addr[9:2]] = m_wdata;

    task automatic chk(input string nm, input int s, input int c, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s scn %0d cyc %0d got %h expected %h", nm, s, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("m_addr", mon_e.scn, mon_e.cyc, m_addr, mon_e.addr);
            chk("m_we", mon_e.scn, mon_e.cyc, m_we, mon_e.we);
            chk("m_wdata", mon_e.scn, mon_e.cyc, m_wdata, mon_e.wd);
            chk("s_stall", mon_e.scn, mon_e.cyc, s_stall, mon_e.stall);
            chk("v_done", mon_e.scn, mon_e.cyc, v_done, mon_e.done);
            chk("v_busy", mon_e.scn, mon_e.cyc, v_busy, mon_e.busy);
            if (mon_e.chk_rd) chk("s_rdata", mon_e.scn, mon_e.cyc, s_rdata, mon_e.rd);
            if (mon_e.chk_vr) chk("v_rdata", mon_e.scn, mon_e.cyc, v_rdata, mon_e.vr);
        end
    end

    // mode: 0 scalar idle, 2 random scalar for 20 cycles, 3 scalar busy until cycle 30, 4 write/read 0x20
    task automatic run_scn(input int n, input bit do_v, input bit vwe, input logic [31:0] vbase,
                           input int mode, input int rst_at);
        logic [127:0] vdat;
        logic sr[64], sw[64];
        logic [31:0] sa[64], sd[64], a;
        exp_t recs[$];
        exp_t e;
        bit bursting = 0, vslot, stall_prev = 0;
        int j = 0, pre = 0, done_at = -1;
        scn++;
        vdat = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < n; t++) begin
            if (t > 0 && stall_prev) begin
                sr[t] = sr[t-1]; sw[t] = sw[t-1]; sa[t] = sa[t-1]; sd[t] = sd[t-1];
            end else begin
                sr[t] = mode == 3 ? (t < 30) : mode == 2 ? (t < 20 && $urandom_range(0, 1) == 1) :
                        mode == 4 ? (t < 2) : 1'b0;
                sw[t] = mode == 4 ? (t == 0) : 1'($urandom_range(0, 1));
                sa[t] = mode == 4 ? 32'h20 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                sd[t] = mode == 4 ? 32'h55 : $urandom;
            end
            e.scn = scn; e.cyc = t; e.addr = 0; e.wd = 0; e.rd = 0; e.we = 0; e.stall = 0;
            e.done = 0; e.busy = 0; e.chk_rd = 0; e.chk_vr = 0;
            if (t == rst_at) begin
                sr[t] = 0;
                vr_model = '0; bursting = 0; done_at = -1; stall_prev = 0;
                e.chk_vr = 1; e.vr = vr_model;
                recs.push_back(e);
                continue;
            end
            vslot = bursting && (!sr[t] || (GUARD && pre == MAX_WAIT));
            if (vslot) begin
                a = vbase + 32'(4 * j);
                e.addr = a; e.we = vwe; e.wd = vdat[j*32 +: 32]; e.stall = sr[t];
                if (vwe) gold[a[9:2]] = e.wd;
                else vr_model[j*32 +: 32] = gold[a[9:2]];
            end else if (sr[t]) begin
                e.addr = sa[t]; e.we = sw[t]; e.wd = sd[t]; e.rd = gold[sa[t][9:2]]; e.chk_rd = 1;
                if (sw[t]) gold[sa[t][9:2]] = sd[t];
            end
            e.done = t == done_at;
            e.busy = bursting || e.done;
            e.chk_vr = e.done;
            e.vr = vr_model;
            if (vslot) begin
                j++; pre = 0;
                if (j == LANES) begin bursting = 0; done_at = t + 1; end
            end else if (bursting) pre++;
            if (do_v && t == 0) begin bursting = 1; j = 0; pre = 0; end
            stall_prev = vslot && sr[t];
            recs.push_back(e);
        end
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) foreach (recs[i]) exp_q.push_back(recs[i]);
            reset = t != rst_at;
            s_req = sr[t]; s_we = sw[t]; s_addr = sa[t]; s_wdata = sd[t];
            v_req = do_v && t == 0;
            v_we = t == 0 ? vwe : 1'($urandom_range(0, 1));
            v_base = t == 0 ? vbase : $urandom;
            v_wdata = t == 0 ? vdat : {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            gold[i] = mem[i];
        end
        run_scn(1, 0, 0, 0, 0, 0);
        run_scn(4, 0, 0, 0, 4, -1);
        run_scn(8, 1, 0, 32'h100, 0, -1);
        run_scn(40, 1, 0, 32'h100, 3, -1);
        run_scn(8, 1, 1, 32'hFFFF_FFF8, 0, -1);
        run_scn(5, 1, 1, 32'h100, 0, 3);
        run_scn(8, 1, 0, 32'h100, 0, -1);
        for (int k = 0; k < 20; k++)
            run_scn(40, 1, 1'($urandom_range(0, 1)), {22'd0, 6'($urandom_range(0, 63)), 4'b0}, 2, -1);
        run_scn(2, 0, 0, 0, 0, -1);
        @(negedge clk);
        #1;
        chk("queue_drained", scn, 0, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_mem_arbiter.md
# vec_mem_arbiter

Arbiter and sequencer for the single data-memory port shared by the scalar pipeline's memory stage and the vector load/store unit. Scalar accesses pass through with zero added latency; vector requests are expanded into a burst of LANES word accesses, slotted into cycles the scalar side leaves free, with an optional starvation guard forcing vector progress. Sits between the pipeline's memory stage, the vector unit and the data memory.

## Interface

Parameters:

- AW, 32, address width.
- DW, 32, data word width.
- LANES, 4, words per vector burst (≥1).
- MAX_WAIT, 4, consecutive preempted burst cycles before the vector side is forced a slot (≥1; used only with guard).

Ports:

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_req  in  1  scalar access this cycle.
- s_we  in  1  scalar write enable.
- s_addr  in  AW  scalar byte address.
- s_wdata  in  DW  scalar write data.
- s_rdata  out  DW  scalar read data (same cycle).
- s_stall  out  1  scalar access denied this cycle; pipeline must hold.
- v_req  in  1  vector burst request (level).
- v_we  in  1  burst is a store.
- v_base  in  AW  burst base byte address.
- v_wdata  in  LANES*DW  store data, lane i at [i*DW +: DW].
- v_rdata  out  LANES*DW  load result, lane i at [i*DW +: DW].
- v_busy  out  1  burst in progress.
- v_done  out  1  one-cycle burst-complete pulse.
- m_we  out  1  memory write enable (write at clock edge).
- m_addr  out  AW  memory byte address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, combinational from m_addr.

## Operation

- FSM: IDLE, VBURST, VDONE.
- IDLE: port owned by scalar. v_req=1 at edge → latch v_base, v_we, v_wdata; beat=0, wait_cnt=0; → VBURST.
- VBURST: vector owns slot if s_req=0, or guard enabled and wait_cnt==MAX_WAIT. Otherwise scalar owns slot and wait_cnt increments.
- Vector slot: m_addr = base + (beat<<2), truncated to AW bits (wraps mod 2^AW); m_we = latched v_we; m_wdata = latched lane[beat]. At edge: if load, capture m_rdata into lane[beat]; beat++; wait_cnt=0. After beat LANES-1 → VDONE.
- VDONE: v_done=1, port owned by scalar; → IDLE. v_req held high in VDONE starts a new burst from the following IDLE cycle.
- v_req during VBURST/VDONE ignored; latched operands do not change mid-burst.
- s_stall = s_req & vector owns slot. Scalar-owned slot: m_addr=s_addr, m_we=s_we&s_req, m_wdata=s_wdata, s_rdata=m_rdata.
- Idle port (no owner requesting): m_we=0, m_addr=0, m_wdata=0.
- v_rdata holds the last completed load; stable until the next load burst's beats write it. Store bursts do not modify v_rdata.
- v_busy=1 in VBURST and VDONE.
- Reset (any state, including mid-burst): → IDLE, beat=0, wait_cnt=0, v_rdata=0, v_done=0, v_busy=0, s_stall=0, m_we=0. Partial bursts are abandoned; writes already committed remain.

## Timing

- Scalar: zero added latency when granted; stalled cycles repeat identically next cycle.
- Uncontended burst: v_req sampled in cycle 0, beats in cycles 1..LANES, v_done in cycle LANES+1, v_rdata valid from cycle LANES+1.
- Fully contended with guard: one vector beat every MAX_WAIT+1 cycles.
- All state updates on rising clk; outputs other than registered state are combinational from state and inputs.

## Configuration

- ARB_STARVE_GUARD_EN defined: wait_cnt and forced vector slot as above.
- Undefined: strict scalar priority; vector beats only when s_req=0; s_stall tied 0; wait_cnt absent.

## Test plan

- Uncontended load: mem[0x100..0x10C]=A,B,C,D, v_req base 0x100, s_req=0 → m_addr 0x100,0x104,0x108,0x10C in cycles 1–4, v_done cycle 5, v_rdata={D,C,B,A}.
- Scalar only: write 0x55 to 0x20 then read 0x20 → s_rdata=0x55 same cycle, s_stall never 1.
- Guard on, MAX_WAIT=4, s_req held high, load burst sampled cycle 0 → vector beats cycles 5,10,15,20 with s_stall=1 exactly those cycles, v_done cycle 21.
- Guard off, same stimulus, s_req drops cycle 30 → no beats before 30, s_stall never 1, beats 30–33, v_done 34.
- Wrap: store burst base 0xFFFFFFF8 → m_addr FFFFFFF8, FFFFFFFC, 00000000, 00000004 with m_we=1.
- Reset asserted after beat 2 → all outputs 0 asynchronously, no v_done; next v_req restarts at beat 0 (m_addr=base).
